// File: rtl/tmds_rx_decoder.sv
// tmds_rx_decoder: receive side of one DVI TMDS channel.
// Finds the word boundary by bitslip on control-token runs, then decodes.
module tmds_rx_decoder #(
   parameter int CTRL_RUN    = 16,
   parameter int SEARCH_WIN  = 4096,
   parameter int SLIP_SETTLE = 8
) (
   input  logic       pix_clk,
   input  logic       rstn,
   input  logic [9:0] tmds_word,
   output logic       bitslip,
   output logic       locked,
   output logic [3:0] slip_cnt,
   output logic       de,
   output logic [1:0] ctrl,
   output logic [7:0] data
);

   localparam logic [7:0]  RUN_MAX  = 8'(CTRL_RUN);
   localparam logic [7:0]  RUN_LAST = 8'(CTRL_RUN - 1);
   localparam logic [15:0] WIN_LAST = 16'(SEARCH_WIN - 1);
   localparam logic [7:0]  SET_LAST = 8'(SLIP_SETTLE - 1);

   typedef enum logic [1:0] {
      S_SEARCH,
      S_SETTLE,
      S_LOCKED
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  rst_sync;
   logic [9:0]  word_q;
   logic        tok;
   logic [1:0]  tok_code;
   logic [7:0]  q;
   logic [7:0]  dec;
   logic        qual;
   logic        expire;
   logic [7:0]  run_cnt;
   logic [7:0]  run_nxt;
   logic [15:0] win_cnt;
   logic [15:0] win_nxt;
   logic [7:0]  set_cnt;
   logic [7:0]  set_nxt;
   logic        bitslip_nxt;
   logic        locked_nxt;
   logic [3:0]  slip_nxt;
   logic        de_nxt;
   logic [1:0]  ctrl_nxt;
   logic [7:0]  data_nxt;

   always_comb begin
      tok      = 1'b1;
      tok_code = 2'b00;
      unique case (1'b1)
         (word_q == 10'h354): tok_code = 2'b00;
         (word_q == 10'h0AB): tok_code = 2'b01;
         (word_q == 10'h154): tok_code = 2'b10;
         (word_q == 10'h2AB): tok_code = 2'b11;
         default:             tok      = 1'b0;
      endcase
   end

   assign q   = word_q[9] ? ~word_q[7:0] : word_q[7:0];
   assign dec = {q[7:1] ^ q[6:0] ^ {7{~word_q[8]}}, q[0]};

   assign qual   = tok && (run_cnt == RUN_LAST);
   assign expire = (win_cnt == WIN_LAST);

   always_comb begin
      state_nxt   = state;
      run_nxt     = run_cnt;
      win_nxt     = win_cnt;
      set_nxt     = set_cnt;
      bitslip_nxt = 1'b0;
      locked_nxt  = locked;
      slip_nxt    = slip_cnt;

      if (state != S_SETTLE) begin
         if (!tok)
            run_nxt = 8'd0;
         else if (run_cnt != RUN_MAX)
            run_nxt = run_cnt + 8'd1;
         win_nxt = qual ? 16'd0 : win_cnt + 16'd1;
      end

      // A qualifying run always beats a window expiry on the same word.
      unique case (state)
         S_SEARCH: begin
            if (qual) begin
               state_nxt  = S_LOCKED;
               locked_nxt = 1'b1;
            end else if (expire) begin
               state_nxt   = S_SETTLE;
               bitslip_nxt = 1'b1;
               slip_nxt    = (slip_cnt == 4'd9) ? 4'd0 : slip_cnt + 4'd1;
               run_nxt     = 8'd0;
               win_nxt     = 16'd0;
            end
         end
         S_SETTLE: begin
            run_nxt = 8'd0;
            win_nxt = 16'd0;
            if (set_cnt == SET_LAST) begin
               set_nxt   = 8'd0;
               state_nxt = S_SEARCH;
            end else begin
               set_nxt = set_cnt + 8'd1;
            end
         end
         S_LOCKED: begin
            if (expire && !qual) begin
               state_nxt  = S_SEARCH;
               locked_nxt = 1'b0;
               slip_nxt   = 4'd0;
               run_nxt    = 8'd0;
               win_nxt    = 16'd0;
            end
         end
         default: state_nxt = S_SEARCH;
      endcase

      ctrl_nxt = tok ? tok_code : ctrl;
      de_nxt   = !tok && locked_nxt;
      data_nxt = de_nxt ? dec : 8'd0;
   end

   // Reset asserts asynchronously; release takes effect two edges later.
   always_ff @(posedge pix_clk or negedge rstn) begin
      if (!rstn) begin
         rst_sync <= 2'b00;
         word_q   <= 10'd0;
         state    <= S_SEARCH;
         run_cnt  <= 8'd0;
         win_cnt  <= 16'd0;
         set_cnt  <= 8'd0;
         bitslip  <= 1'b0;
         locked   <= 1'b0;
         slip_cnt <= 4'd0;
         de       <= 1'b0;
         ctrl     <= 2'b00;
         data     <= 8'd0;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
         word_q   <= tmds_word;
         if (rst_sync[1]) begin
            state    <= state_nxt;
            run_cnt  <= run_nxt;
            win_cnt  <= win_nxt;
            set_cnt  <= set_nxt;
            bitslip  <= bitslip_nxt;
            locked   <= locked_nxt;
            slip_cnt <= slip_nxt;
            de       <= de_nxt;
            ctrl     <= ctrl_nxt;
            data     <= data_nxt;
         end
      end
   end

endmodule
